pll_cal_seq: RTL
================

# pll_cal_seq

Calibration sequencer for the fast auto freq-ctrl (FAFC) block. It owns FAFC's reset and enable and runs the bring-up: reset FAFC, release it, and wait for the SAR search to assert FREQLOCK2 within a timeout. It then settles, hands over to the fine PLL loop, and retries or flags failure on timeout or lock loss. It sits between the SPI register bank and FAFC, clocked by REF.

## Interface
- RST_CYC, 4: REF cycles FAFC_NARST is held low per attempt (≥2; FAFC's internal reset synchroniser needs it).
- TMO_W, 12: width of the lock-timeout counter and SPI_CAL_TMO.
- MAX_RETRY, 2: retries after the first attempt; range 0..3.
- REF  in  1  reference clock; all state updates on rising edge.
- ARST  in  1  asynchronous, active-high reset.
- CAL_START  in  1  start/restart request, sampled each edge.
- CAL_ABORT  in  1  abort request; overrides everything.
- FREQLOCK2  in  1  FAFC SAR-done flag.
- SPI_CAL_TMO  in  TMO_W  lock timeout in REF cycles; 0 = no timeout.
- SPI_SETTLE  in  8  settle time after lock, in REF cycles.
- FAFC_NARST  out  1  drives FAFC SPI_NARST (active-low).
- FAFC_EN  out  1  drives FAFC SPI_FAFC_EN.
- LOOP_EN  out  1  enables the fine PLL loop.
- CAL_BUSY  out  1  high in RST, RUN and SETTLE.
- CAL_DONE  out  1  high in LOCKED.
- CAL_FAIL  out  1  high in FAIL.
- RETRY_CNT  out  2  retries consumed in the current calibration.
- STATE  out  3  encoded state, for debug.

## Operation
- States and encodings: IDLE=0, RST=1, RUN=2, SETTLE=3, LOCKED=4, FAIL=5. Codes 6 and 7 go to IDLE on the next edge.
- Outputs are Moore-decoded from registered state, so there is no combinational input-to-output path.
- Outputs per state:
  - IDLE: FAFC_NARST=0, FAFC_EN=0, LOOP_EN=0.
  - RST: FAFC_NARST=0, FAFC_EN=1.
  - RUN: FAFC_NARST=1, FAFC_EN=1, LOOP_EN=0.
  - SETTLE, LOCKED: FAFC_NARST=1, FAFC_EN=1, LOOP_EN=1.
  - FAIL: FAFC_NARST=0, FAFC_EN=0, LOOP_EN=0.
- FAFC_EN is never dropped while FAFC holds a result; dropping it would return the MMD init codes to their defaults.
- One shared down-counter CNT serves RST, RUN and SETTLE, and is loaded on every state entry.
- Transition priority, highest first:
  1. CAL_ABORT → IDLE.
  2. CAL_START → RST, with RETRY_CNT=0.
  3. The per-state rules below.
- CAL_START is accepted in every state, including mid-calibration; it always restarts from RST.
- IDLE: waits for CAL_START.
- RST: held for RST_CYC cycles, then → RUN.
- RUN:
  - FREQLOCK2=1 → SETTLE.
  - Otherwise, after SPI_CAL_TMO cycles → timeout.
  - If lock and the timeout expiry happen on the same edge, lock wins.
  - SPI_CAL_TMO=0: RUN waits forever.
- SETTLE: held for max(SPI_SETTLE,1) cycles, then → LOCKED.
- Lock loss (FREQLOCK2=0 in SETTLE or LOCKED) is handled exactly like a timeout.
- Timeout or lock loss:
  - If RETRY_CNT<MAX_RETRY: RETRY_CNT increments and the state goes → RST.
  - Otherwise → FAIL, and RETRY_CNT holds.
- LOCKED and FAIL are sticky until CAL_START or CAL_ABORT.
- SPI_CAL_TMO and SPI_SETTLE are sampled only when CNT loads; a change mid-count has no effect.

## Timing
- ARST is asynchronous. While it is high, and after release:
  - STATE=IDLE, CNT=0, RETRY_CNT=0.
  - FAFC_NARST=0, FAFC_EN=0, LOOP_EN=0.
  - CAL_BUSY=0, CAL_DONE=0, CAL_FAIL=0.
- ARST asserted mid-operation forces these values immediately, without waiting for an edge.
- Let edge 0 be the edge that samples CAL_START=1:
  - RST covers edges 0 to RST_CYC.
  - RUN starts at edge RST_CYC.
- FREQLOCK2 is sampled 1 at edge L:
  - SETTLE starts at edge L.
  - LOCKED starts at edge L+max(SPI_SETTLE,1).
- Timeout fires at edge (RUN entry)+SPI_CAL_TMO.
- FREQLOCK2 is used directly, without a synchroniser; both blocks share REF.
- CAL_START and CAL_ABORT are level-sampled. CAL_START held high restarts every cycle, and stays in RST, so the source must pulse it for exactly one cycle.

## Test plan
All scenarios use RST_CYC=4, MAX_RETRY=2, SPI_CAL_TMO=100, SPI_SETTLE=8.
- Nominal lock:
  - Stimulus: START at edge 0; FREQLOCK2 rises at edge 30.
  - Response: FAFC_NARST=0 for edges 0–3 and 1 from edge 4; SETTLE at edge 30; LOCKED with CAL_DONE=1 at edge 38; RETRY_CNT=0.
- Retry exhaustion:
  - Stimulus: FREQLOCK2 held 0.
  - Response: RUN 4–104, RST 104–108 with RETRY_CNT=1, RUN 108–208, RST 208–212 with RETRY_CNT=2, RUN 212–312; FAIL at edge 312 with CAL_FAIL=1 and FAFC_EN=0.
- Lock at the timeout boundary:
  - Stimulus: FREQLOCK2 rises exactly at edge 104.
  - Response: SETTLE at edge 104, not RST; RETRY_CNT stays 0.
- Lock loss:
  - Stimulus: from LOCKED at edge 38, FREQLOCK2 drops at edge 50.
  - Response: RST at edge 50 with RETRY_CNT=1; CAL_DONE=0 and LOOP_EN=0 from edge 50.
- Abort/start collision and async reset:
  - Stimulus: CAL_ABORT and CAL_START both high at edge 60; then ARST pulsed during RUN.
  - Response: IDLE after edge 60; ARST gives all outputs 0 immediately, with no edge required.
- Zero timeout:
  - Stimulus: SPI_CAL_TMO=0; FREQLOCK2 rises at edge 5000.
  - Response: RUN holds with no retry; SETTLE at edge 5000.

Source files
------------

// File: rtl/pll_cal_seq.sv
// rtl/pll_cal_seq.sv - FAFC calibration sequencer: reset, SAR lock wait, settle, handover, retry/fail.
module pll_cal_seq #(
    parameter int RST_CYC   = 4,
    parameter int TMO_W     = 12,
    parameter int MAX_RETRY = 2
) (
    input  logic             ref_i,
    input  logic             arst_i,
    input  logic             cal_start_i,
    input  logic             cal_abort_i,
    input  logic             freqlock2_i,
    input  logic [TMO_W-1:0] spi_cal_tmo_i,
    input  logic [7:0]       spi_settle_i,
    output logic             fafc_narst_o,
    output logic             fafc_en_o,
    output logic             loop_en_o,
    output logic             cal_busy_o,
    output logic             cal_done_o,
    output logic             cal_fail_o,
    output logic [1:0]       retry_cnt_o,
    output logic [2:0]       state_o
);

    localparam int CW0 = (TMO_W > 8) ? TMO_W : 8;
    localparam int CW  = (CW0 > $clog2(RST_CYC + 1)) ? CW0 : $clog2(RST_CYC + 1);
    localparam logic [1:0] MAX_R = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      retry_q, retry_d;
    logic            fault;
    logic [CW-1:0]   rst_load, tmo_load, settle_load;

    assign rst_load    = CW'(RST_CYC);
    assign tmo_load    = CW'(spi_cal_tmo_i);
    assign settle_load = (spi_settle_i == 8'd0) ? CW'(1) : CW'(spi_settle_i);

    always_ff @(posedge ref_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            retry_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // CNT counts down to 1; a RUN count parked at 0 means "no timeout".
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        fault   = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_RST: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_RUN;
                    cnt_d   = tmo_load;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RUN: begin
                if (freqlock2_i) begin
                    state_d = S_SETTLE;
                    cnt_d   = settle_load;
                end else if (cnt_q == CW'(1)) begin
                    fault = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SETTLE: begin
                if (!freqlock2_i) begin
                    fault = 1'b1;
                end else if (cnt_q <= CW'(1)) begin
                    state_d = S_LOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_LOCKED: fault = !freqlock2_i;
            S_FAIL: ;
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (fault) begin
            if (retry_q < MAX_R) begin
                retry_d = retry_q + 2'd1;
                state_d = S_RST;
                cnt_d   = rst_load;
            end else begin
                state_d = S_FAIL;
                cnt_d   = '0;
            end
        end
        if (cal_start_i) begin
            state_d = S_RST;
            cnt_d   = rst_load;
            retry_d = 2'd0;
        end
        if (cal_abort_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        fafc_narst_o = 1'b0;
        fafc_en_o    = 1'b0;
        loop_en_o    = 1'b0;
        cal_busy_o   = 1'b0;
        cal_done_o   = 1'b0;
        cal_fail_o   = 1'b0;
        case (state_q)
            S_RST: begin
                fafc_en_o  = 1'b1;
                cal_busy_o = 1'b1;
            end
            S_RUN: begin
                fafc_narst_o = 1'b1;
                fafc_en_o    = 1'b1;
                cal_busy_o   = 1'b1;
            end
            S_SETTLE: begin
                fafc_narst_o = 1'b1;
                fafc_en_o    = 1'b1;
                loop_en_o    = 1'b1;
                cal_busy_o   = 1'b1;
            end
            S_LOCKED: begin
                fafc_narst_o = 1'b1;
                fafc_en_o    = 1'b1;
                loop_en_o    = 1'b1;
                cal_done_o   = 1'b1;
            end
            S_FAIL:  cal_fail_o = 1'b1;
            default: ;
        endcase
    end

    assign retry_cnt_o = retry_q;
    assign state_o     = state_q;

endmodule
